// File: rtl/ddr_tgt_rx.sv
// Receive side of the DDR target link: decodes preamble/data/parity words carried on both SCL
// edges and emits accepted command words, register-file byte writes and the trailing CRC.
module ddr_tgt_rx #(
   parameter logic [9:0]  ADDR_BASE    = 10'd0,
   parameter int unsigned MIN_EDGE_GAP = 2
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic        i_tgt_en,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_cmd_valid,
   output logic [15:0] o_cmd_word,
   output logic        o_regf_wr_en,
   output logic [7:0]  o_regf_data,
   output logic [9:0]  o_regf_addr,
   output logic        o_crc_valid,
   output logic [4:0]  o_crc_value,
   output logic        o_frame_done,
   output logic        o_err,
   output logic [1:0]  o_err_type
);

   typedef enum logic [2:0] {
      StIdle, StPre, StData, StPar, StCrcTok, StCrcVal, StErr
   } state_e;

   if (MIN_EDGE_GAP < 1) begin : g_gap_check
      $error("MIN_EDGE_GAP must be at least 1");
   end

   state_e      state_q;
   logic        scl_q, live_q, first_q, is_cmd_q, pend2_q;
   logic [4:0]  cnt_q;
   logic [14:0] shift_q;
   logic [15:0] word_q;
   logic        cmd_valid_q, wr_en_q, crc_valid_q, frame_done_q, err_q;
   logic [15:0] cmd_word_q;
   logic [7:0]  data_q;
   logic [9:0]  addr_q;
   logic [4:0]  crc_value_q;
   logic [1:0]  err_type_q;

   logic        scl_edge;
   logic [15:0] word_in;
   logic [1:0]  par_exp;

   // live_q masks the cycle in which reset is released so a stale scl_q is not seen as an edge.
   assign scl_edge = live_q && (i_scl != scl_q);
   assign word_in  = {shift_q, i_sda};
   assign par_exp  = {^(word_q & 16'hAAAA), ~^(word_q & 16'h5555)};

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q      <= StIdle;
         scl_q        <= 1'b0;
         live_q       <= 1'b0;
         first_q      <= 1'b0;
         is_cmd_q     <= 1'b0;
         pend2_q      <= 1'b0;
         cnt_q        <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_word_q   <= '0;
         wr_en_q      <= 1'b0;
         data_q       <= '0;
         addr_q       <= ADDR_BASE;
         crc_valid_q  <= 1'b0;
         crc_value_q  <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         err_type_q   <= '0;
      end else begin
         scl_q        <= i_scl;
         live_q       <= 1'b1;
         cmd_valid_q  <= 1'b0;
         wr_en_q      <= 1'b0;
         crc_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (wr_en_q) begin
            addr_q <= addr_q + 10'd1;
         end
         if (!i_tgt_en) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            pend2_q    <= 1'b0;
            err_q      <= 1'b0;
            err_type_q <= '0;
         end else begin
            if (pend2_q) begin
               wr_en_q <= 1'b1;
               data_q  <= word_q[7:0];
               pend2_q <= 1'b0;
            end
            if (scl_edge && state_q != StErr) begin
               cnt_q   <= cnt_q + 5'd1;
               shift_q <= word_in[14:0];
               unique case (state_q)
                  // The starting edge already carries the first preamble bit.
                  StIdle: begin
                     state_q <= StPre;
                     first_q <= 1'b1;
                     addr_q  <= ADDR_BASE;
                  end
                  StPre: begin
                     if (cnt_q == 5'd1) begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                        if (word_in[1:0] == 2'b01 && first_q) begin
                           state_q  <= StData;
                           is_cmd_q <= 1'b1;
                        end else if (word_in[1:0] == 2'b10 && !first_q) begin
                           state_q  <= StData;
                           is_cmd_q <= 1'b0;
                        end else if (word_in[1:0] == 2'b01) begin
                           state_q <= StCrcTok;
                        end else begin
                           state_q    <= StErr;
                           err_q      <= 1'b1;
                           err_type_q <= 2'b11;
                        end
                     end
                  end
                  StData: begin
                     if (cnt_q == 5'd15) begin
                        word_q  <= word_in;
                        state_q <= StPar;
                        cnt_q   <= '0;
                        shift_q <= '0;
                     end
                  end
                  StPar: begin
                     if (cnt_q == 5'd1) begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                        if (word_in[1:0] == par_exp) begin
                           state_q <= StPre;
                           first_q <= 1'b0;
                           if (is_cmd_q) begin
                              cmd_word_q  <= word_q;
                              cmd_valid_q <= 1'b1;
                           end else begin
                              wr_en_q <= 1'b1;
                              data_q  <= word_q[15:8];
                              pend2_q <= 1'b1;
                           end
                        end else begin
                           state_q    <= StErr;
                           err_q      <= 1'b1;
                           err_type_q <= 2'b01;
                        end
                     end
                  end
                  StCrcTok: begin
                     if (cnt_q == 5'd3) begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                        if (word_in[3:0] == 4'hC) begin
                           state_q <= StCrcVal;
                        end else begin
                           state_q    <= StErr;
                           err_q      <= 1'b1;
                           err_type_q <= 2'b10;
                        end
                     end
                  end
                  StCrcVal: begin
                     if (cnt_q == 5'd4) begin
                        cnt_q        <= '0;
                        shift_q      <= '0;
                        crc_value_q  <= word_in[4:0];
                        crc_valid_q  <= 1'b1;
                        frame_done_q <= 1'b1;
                        state_q      <= StIdle;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_cmd_valid  = cmd_valid_q;
   assign o_cmd_word   = cmd_word_q;
   assign o_regf_wr_en = wr_en_q;
   assign o_regf_data  = data_q;
   assign o_regf_addr  = addr_q;
   assign o_crc_valid  = crc_valid_q;
   assign o_crc_value  = crc_value_q;
   assign o_frame_done = frame_done_q;
   assign o_err        = err_q;
   assign o_err_type   = err_type_q;

endmodule

// File: tb/tb_ddr_tgt_rx.sv
// Bench for ddr_tgt_rx: two instances (ADDR_BASE 0 and 3FF) share one bus and are checked
// against an event-list model of each frame, plus directed abort/reset sequences.
module tb_ddr_tgt_rx;

   localparam logic [9:0] BASE1 = 10'h3FF;

   typedef logic [31:0] ev_t;
   typedef ev_t evq_t[$];

   typedef struct {
      logic [1:0]       pre0;
      logic [15:0]      cmd;
      int               nd;
      logic [2:0][15:0] d;
      logic [3:0]       tok;
      logic [4:0]       crc;
      int               flip;  // 0 none, 1 command word, k+2 data word k
   } frame_t;

   typedef struct {
      frame_t      f;
      logic [1:0]  err;
      int          nwr;
      int          ncrc;
      logic [17:0] last0;
      logic [17:0] last1;
      logic [15:0] cmd_word;
      logic [4:0]  crc_value;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, en, scl, sda;

   logic cv0, wv0, rv0, fd0, er0, cv1, wv1, rv1, fd1, er1;
   logic [15:0] cw0, cw1;
   logic [7:0]  rd0, rd1;
   logic [9:0]  ra0, ra1;
   logic [4:0]  cr0, cr1;
   logic [1:0]  et0, et1;

   int n_checks = 0;
   int n_fail = 0;
   evq_t obs0, obs1, exp0, exp1;
   logic [1:0] exp_err;
   vec_t vecs[7];

   always #5 clk = ~clk;

   ddr_tgt_rx #(.ADDR_BASE(10'd0), .MIN_EDGE_GAP(2)) dut0 (
      .i_sys_clk(clk), .i_sys_rst(rst_n), .i_tgt_en(en), .i_scl(scl), .i_sda(sda),
      .o_cmd_valid(cv0), .o_cmd_word(cw0), .o_regf_wr_en(wv0), .o_regf_data(rd0),
      .o_regf_addr(ra0), .o_crc_valid(rv0), .o_crc_value(cr0), .o_frame_done(fd0),
      .o_err(er0), .o_err_type(et0)
   );

   ddr_tgt_rx #(.ADDR_BASE(BASE1), .MIN_EDGE_GAP(2)) dut1 (
      .i_sys_clk(clk), .i_sys_rst(rst_n), .i_tgt_en(en), .i_scl(scl), .i_sda(sda),
      .o_cmd_valid(cv1), .o_cmd_word(cw1), .o_regf_wr_en(wv1), .o_regf_data(rd1),
      .o_regf_addr(ra1), .o_crc_valid(rv1), .o_crc_value(cr1), .o_frame_done(fd1),
      .o_err(er1), .o_err_type(et1)
   );

   function automatic ev_t ev_wr(input logic [9:0] a, input logic [7:0] b);
      return {2'd1, 4'd0, a, b, 8'd0};
   endfunction
   function automatic ev_t ev_cmd(input logic [15:0] w);
      return {2'd2, 14'd0, w};
   endfunction
   function automatic ev_t ev_crc(input logic [4:0] c);
      return {2'd3, 25'd0, c};
   endfunction
   function automatic ev_t ev_done();
      return 32'h0000_0001;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (wv0) obs0.push_back(ev_wr(ra0, rd0));
         if (cv0) obs0.push_back(ev_cmd(cw0));
         if (rv0) obs0.push_back(ev_crc(cr0));
         if (fd0) obs0.push_back(ev_done());
         if (wv1) obs1.push_back(ev_wr(ra1, rd1));
         if (cv1) obs1.push_back(ev_cmd(cw1));
         if (rv1) obs1.push_back(ev_crc(cr1));
         if (fd1) obs1.push_back(ev_done());
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_q(input string name, input evq_t o, input evq_t e);
      int n;
      check({name, "_count"}, 32'(o.size()), 32'(e.size()));
      n = (o.size() < e.size()) ? o.size() : e.size();
      for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", name, i), o[i], e[i]);
   endtask

   // Frame-level model: what each instance must report, in order, and the final error type.
   task automatic build_exp(input frame_t f);
      logic [9:0] a0;
      logic [7:0] bt;
      exp0.delete();
      exp1.delete();
      exp_err = 2'b00;
      if (f.pre0 != 2'b01) begin exp_err = 2'b11; return; end
      if (f.flip == 1) begin exp_err = 2'b01; return; end
      exp0.push_back(ev_cmd(f.cmd));
      exp1.push_back(ev_cmd(f.cmd));
      for (int k = 0; k < f.nd; k++) begin
         if (f.flip == k + 2) begin exp_err = 2'b01; return; end
         for (int b = 0; b < 2; b++) begin
            a0 = 10'(2 * k + b);
            bt = (b == 0) ? f.d[k][15:8] : f.d[k][7:0];
            exp0.push_back(ev_wr(a0, bt));
            exp1.push_back(ev_wr(a0 + BASE1, bt));
         end
      end
      if (f.tok != 4'hC) begin exp_err = 2'b10; return; end
      exp0.push_back(ev_crc(f.crc));
      exp0.push_back(ev_done());
      exp1.push_back(ev_crc(f.crc));
      exp1.push_back(ev_done());
   endtask

   task automatic send_bit(input logic b);
      repeat ($urandom_range(2, 4)) @(negedge clk);
      sda = b;
      scl = ~scl;
   endtask

   task automatic send_word(input logic [1:0] pre, input logic [15:0] w, input logic flip);
      send_bit(pre[1]);
      send_bit(pre[0]);
      for (int i = 15; i >= 0; i--) send_bit(w[i]);
      send_bit(^(w & 16'hAAAA));
      send_bit(~(^(w & 16'h5555)) ^ flip);
   endtask

   task automatic send_frame(input frame_t f);
      send_word(f.pre0, f.cmd, f.flip == 1);
      for (int k = 0; k < f.nd; k++) send_word(2'b10, f.d[k], f.flip == k + 2);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 3; i >= 0; i--) send_bit(f.tok[i]);
      for (int i = 4; i >= 0; i--) send_bit(f.crc[i]);
   endtask

   task automatic run_frame(input string tag, input frame_t f);
      obs0.delete();
      obs1.delete();
      build_exp(f);
      en = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(f);
      repeat (8) @(negedge clk);
      compare_q({tag, "_ev0"}, obs0, exp0);
      compare_q({tag, "_ev1"}, obs1, exp1);
      check({tag, "_err0"}, 32'({er0, et0}), 32'({exp_err != 2'b00, exp_err}));
      check({tag, "_err1"}, 32'({er1, et1}), 32'({exp_err != 2'b00, exp_err}));
   endtask

   task automatic end_frame(input string tag);
      en = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_err_clear"}, 32'({er0, et0, er1, et1}), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_strobes0"}, 32'({cv0, wv0, rv0, fd0, er0, et0}), 32'd0);
      check({tag, "_strobes1"}, 32'({cv1, wv1, rv1, fd1, er1, et1}), 32'd0);
      check({tag, "_cmd_word"}, 32'(cw0), 32'd0);
      check({tag, "_data_crc"}, 32'({rd0, cr0}), 32'd0);
      check({tag, "_addr0"}, 32'(ra0), 32'h000);
      check({tag, "_addr1"}, 32'(ra1), 32'h3FF);
   endtask

   function automatic frame_t mk_frame(input logic [1:0] pre0, input logic [15:0] cmd,
                                       input int nd, input logic [15:0] d0,
                                       input logic [15:0] d1, input logic [3:0] tok,
                                       input logic [4:0] crc, input int flip);
      frame_t f;
      f.pre0 = pre0;
      f.cmd  = cmd;
      f.nd   = nd;
      f.d[0] = d0;
      f.d[1] = d1;
      f.d[2] = 16'h0000;
      f.tok  = tok;
      f.crc  = crc;
      f.flip = flip;
      return f;
   endfunction

   function automatic vec_t mk_vec(input frame_t f, input logic [1:0] err, input int nwr,
                                   input int ncrc, input logic [17:0] last0,
                                   input logic [17:0] last1, input logic [15:0] cmd_word,
                                   input logic [4:0] crc_value);
      vec_t v;
      v.f = f;
      v.err = err;
      v.nwr = nwr;
      v.ncrc = ncrc;
      v.last0 = last0;
      v.last1 = last1;
      v.cmd_word = cmd_word;
      v.crc_value = crc_value;
      return v;
   endfunction

   initial begin
      frame_t f;
      int nwr, ncrc;
      logic [17:0] last;
      string tag;

      vecs[0] = mk_vec(mk_frame(2'b01, 16'h2A05, 0, 16'h0, 16'h0, 4'hC, 5'h13, 0),
                       2'b00, 0, 1, 18'h0, 18'h0, 16'h2A05, 5'h13);
      vecs[1] = mk_vec(mk_frame(2'b01, 16'h0001, 2, 16'hA55A, 16'h0102, 4'hC, 5'h1F, 0),
                       2'b00, 4, 1, {10'h003, 8'h02}, {10'h002, 8'h02}, 16'h0001, 5'h1F);
      vecs[2] = mk_vec(mk_frame(2'b01, 16'h0100, 1, 16'hFFFF, 16'h0, 4'hC, 5'h07, 2),
                       2'b01, 0, 0, 18'h0, 18'h0, 16'h0100, 5'h1F);
      vecs[3] = mk_vec(mk_frame(2'b01, 16'h00FF, 0, 16'h0, 16'h0, 4'hA, 5'h05, 0),
                       2'b10, 0, 0, 18'h0, 18'h0, 16'h00FF, 5'h1F);
      vecs[4] = mk_vec(mk_frame(2'b10, 16'hBEEF, 0, 16'h0, 16'h0, 4'hC, 5'h11, 0),
                       2'b11, 0, 0, 18'h0, 18'h0, 16'h00FF, 5'h1F);
      vecs[5] = mk_vec(mk_frame(2'b01, 16'h0003, 1, 16'h1234, 16'h0, 4'hC, 5'h0A, 0),
                       2'b00, 2, 1, {10'h001, 8'h34}, {10'h000, 8'h34}, 16'h0003, 5'h0A);
      vecs[6] = mk_vec(mk_frame(2'b01, 16'h7FFF, 0, 16'h0, 16'h0, 4'hC, 5'h02, 1),
                       2'b01, 0, 0, 18'h0, 18'h0, 16'h0003, 5'h0A);

      rst_n = 1'b0;
      en = 1'b0;
      scl = 1'b0;
      sda = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         tag = $sformatf("vec%0d", i);
         run_frame(tag, vecs[i].f);
         nwr = 0;
         ncrc = 0;
         last = '0;
         foreach (obs0[j]) begin
            if (obs0[j][31:30] == 2'd1) begin nwr++; last = {obs0[j][25:16], obs0[j][15:8]}; end
            if (obs0[j][31:30] == 2'd3) ncrc++;
         end
         check({tag, "_nwr"}, 32'(nwr), 32'(vecs[i].nwr));
         check({tag, "_ncrc"}, 32'(ncrc), 32'(vecs[i].ncrc));
         check({tag, "_err_type"}, 32'(et0), 32'(vecs[i].err));
         check({tag, "_cmd_word"}, 32'(cw0), 32'(vecs[i].cmd_word));
         check({tag, "_crc_value"}, 32'(cr1), 32'(vecs[i].crc_value));
         if (vecs[i].nwr > 0) begin
            check({tag, "_last_wr0"}, 32'(last), 32'(vecs[i].last0));
            last = (obs1.size() > 0) ? {obs1[$][25:16], obs1[$][15:8]} : 18'h0;
            foreach (obs1[j]) if (obs1[j][31:30] == 2'd1) last = {obs1[j][25:16], obs1[j][15:8]};
            check({tag, "_last_wr1"}, 32'(last), 32'(vecs[i].last1));
         end
         end_frame(tag);
      end

      // Command/byte latency and suppression of the second byte when enable drops.
      obs0.delete();
      obs1.delete();
      en = 1'b1;
      repeat (2) @(negedge clk);
      send_word(2'b01, 16'h0F0F, 1'b0);
      @(negedge clk);
      check("cmd_latency", 32'({cv0, cw0}), 32'({1'b1, 16'h0F0F}));
      @(negedge clk);
      check("cmd_pulse_width", 32'(cv0), 32'd0);
      send_word(2'b10, 16'hC35A, 1'b0);
      @(negedge clk);
      check("byte1_latency", 32'({wv0, rd0, ra0}), 32'({1'b1, 8'hC3, 10'h000}));
      en = 1'b0;
      @(negedge clk);
      check("byte2_suppressed", 32'({wv0, wv1}), 32'd0);
      repeat (2) @(negedge clk);
      exp0 = {ev_cmd(16'h0F0F), ev_wr(10'h000, 8'hC3)};
      exp1 = {ev_cmd(16'h0F0F), ev_wr(10'h3FF, 8'hC3)};
      compare_q("abort_pend_ev0", obs0, exp0);
      compare_q("abort_pend_ev1", obs1, exp1);

      // Abort inside the second data word, then a fresh frame must restart at ADDR_BASE.
      obs0.delete();
      obs1.delete();
      en = 1'b1;
      repeat (2) @(negedge clk);
      send_word(2'b01, 16'h1357, 1'b0);
      send_word(2'b10, 16'hBEEF, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      repeat (6) send_bit(1'b1);
      @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
      exp0 = {ev_cmd(16'h1357), ev_wr(10'h000, 8'hBE), ev_wr(10'h001, 8'hEF)};
      exp1 = {ev_cmd(16'h1357), ev_wr(10'h3FF, 8'hBE), ev_wr(10'h000, 8'hEF)};
      compare_q("abort_data_ev0", obs0, exp0);
      compare_q("abort_data_ev1", obs1, exp1);
      check("abort_no_err", 32'({er0, et0}), 32'd0);
      run_frame("restart", mk_frame(2'b01, 16'h0042, 1, 16'h6789, 16'h0, 4'hC, 5'h15, 0));
      end_frame("restart");

      // Asynchronous reset in the middle of a frame, between clock edges.
      en = 1'b1;
      repeat (2) @(negedge clk);
      send_word(2'b01, 16'hC3A5, 1'b0);
      send_word(2'b10, 16'h55AA, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("areset");
      en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int r = 0; r < 20; r++) begin
         f.pre0 = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         f.cmd  = 16'($urandom);
         f.nd   = int'($urandom_range(0, 3));
         for (int k = 0; k < 3; k++) f.d[k] = 16'($urandom);
         f.tok  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hC;
         f.crc  = 5'($urandom);
         f.flip = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, f.nd + 1)) : 0;
         tag = $sformatf("rnd%0d", r);
         run_frame(tag, f);
         end_frame(tag);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
